load_store_unit: RTL and testbench

Data-memory stage directly downstream of the ALU in the rv32i core. It takes the ALU result as the effective address and rs2 as store data, then runs a req/gnt/rvalid handshake to data memory. It stalls the single-cycle core while the access is in flight and returns the byte/half/word load result, sign- or zero-extended, for writeback.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 tb/tb_load_store_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state type and lane helpers for the rv32i load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } lsu_state_e;

   // Byte enables: byte and half rotate by the low address bits, anything else is a full word
   function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3)
         F3_B:    be = 4'b0001 << off;
         F3_H:    be = 4'b0011 << {off[1], 1'b0};
         F3_W:    be = 4'b1111;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Stores decode width from the exact funct3, loads from funct3[1:0]
   function automatic logic is_misaligned(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
      logic half;
      logic word;
      half = we ? (f3 == F3_H) : (f3[1:0] == 2'b01);
      word = we ? ((f3 != F3_B) && (f3 != F3_H)) : f3[1];
      return (half & off[0]) | (word & (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension,
// store data replication and byte-enable generation.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      ld_func_3,
   input  logic [1:0]      ld_off,
   input  logic [XLEN-1:0] ld_word,
   input  logic [2:0]      st_func_3,
   input  logic [1:0]      st_off,
   input  logic [XLEN-1:0] st_data,
   output logic [XLEN-1:0] ld_data_c,
   output logic [XLEN-1:0] st_data_c,
   output logic [3:0]      st_be_c
);

   localparam int unsigned LANES = XLEN / 8;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = ld_word[{ld_off, 3'b000} +: 8];
   assign ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];

   always_comb begin
      ld_data_c = ld_word;
      case (ld_func_3)
         F3_B:    ld_data_c = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data_c = {{(XLEN-8){1'b0}}, ld_byte};
         F3_H:    ld_data_c = {{(XLEN-16){ld_half[15]}}, ld_half};
         F3_HU:   ld_data_c = {{(XLEN-16){1'b0}}, ld_half};
         F3_W:    ld_data_c = ld_word;
         default: ld_data_c = ld_word;
      endcase
   end

   always_comb begin
      st_data_c = st_data;
      case (st_func_3)
         F3_B:    st_data_c = {LANES{st_data[7:0]}};
         F3_H:    st_data_c = {(LANES/2){st_data[15:0]}};
         default: st_data_c = st_data;
      endcase
   end

   assign st_be_c = be_gen(st_func_3, st_off);

endmodule

// File: rtl/load_store_unit.sv
// rv32i data-memory stage: req/gnt/rvalid handshake with core stall and timeout abort.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating the address.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      func_3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic [XLEN-1:0] rdata,
   output logic            bus_err,
   output logic            misaligned,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic             we_q;
   logic             access, trap, timeout;
   logic [XLEN-1:0]  ld_data_c, st_data_c;
   logic [3:0]       st_be_c;

   assign access  = mem_read | mem_write;
   assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));
   assign stall   = access & (state_q != DONE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = access & is_misaligned(mem_write, func_3, addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   // Stores take their lanes from the live inputs; loads extract with the latched offset
   lsu_align #(.XLEN(XLEN)) u_align (
      .ld_func_3 (f3_q),
      .ld_off    (off_q),
      .ld_word   (dmem_rdata),
      .st_func_3 (func_3),
      .st_off    (addr[1:0]),
      .st_data   (wdata),
      .ld_data_c (ld_data_c),
      .st_data_c (st_data_c),
      .st_be_c   (st_be_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (access) state_d = trap ? DONE : REQ;
         REQ: begin
            if (dmem_gnt)     state_d = we_q ? DONE : WAIT;
            else if (timeout) state_d = DONE;
         end
         WAIT:    if (dmem_rvalid || timeout) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         we_q       <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_be    <= '0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         rdata      <= '0;
         bus_err    <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         bus_err    <= 1'b0;
         misaligned <= 1'b0;
         // Wait counter restarts on every state change, so REQ and WAIT each get MAX_WAIT cycles
         if (state_d != state_q)                     cnt_q <= '0;
         else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
         case (state_q)
            IDLE: if (access) begin
               f3_q  <= func_3;
               off_q <= addr[1:0];
               we_q  <= mem_write;
               if (trap) begin
                  misaligned <= 1'b1;
                  if (!mem_write) rdata <= '0;
               end else begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write;
                  dmem_be    <= st_be_c;
                  dmem_addr  <= {addr[XLEN-1:2], 2'b00};
                  dmem_wdata <= st_data_c;
               end
            end
            REQ: if (dmem_gnt || timeout) begin
               dmem_req <= 1'b0;
               if (!dmem_gnt) begin
                  bus_err <= 1'b1;
                  if (!we_q) rdata <= '0;
               end
            end
            WAIT: begin
               if (dmem_rvalid) rdata <= ld_data_c;
               else if (timeout) begin
                  bus_err <= 1'b1;
                  rdata   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus randomized accesses
// against an arithmetic reference model of the load/store lane rules.
module tb_load_store_unit;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned MAX_WAIT = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            mem_read, mem_write;
   logic [2:0]      func_3;
   logic [XLEN-1:0] addr, wdata;
   logic            stall;
   logic [XLEN-1:0] rdata;
   logic            bus_err, misaligned;
   logic            dmem_req, dmem_we;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_addr, dmem_wdata;
   logic            dmem_gnt, dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;

   load_store_unit #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .func_3      (func_3),
      .addr        (addr),
      .wdata       (wdata),
      .stall       (stall),
      .rdata       (rdata),
      .bus_err     (bus_err),
      .misaligned  (misaligned),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_be     (dmem_be),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      bit          rd;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] word;
      int          gd;
      int          rv;
      bit          hold;
   } txn_t;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      bit          chk_be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      int          stall_cyc;
      int          req_cyc;
   } exp_done_t;

   exp_req_t    req_q[$];
   exp_done_t   done_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_rdata;
   int          stall_m, reqc_m;
   bit          req_prev;
   exp_req_t    mon_er;
   exp_done_t   mon_ed;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int nbytes(input bit w, input logic [2:0] f3);
      if (w) return (f3 == 3'd0) ? 1 : ((f3 == 3'd1) ? 2 : 4);
      return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
   endfunction

   function automatic int lane_off(input int nb, input logic [31:0] a);
      return (int'(a % 4) / nb) * nb;
   endfunction

   function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] word);
      int     nb;
      longint v;
      nb = nbytes(1'b0, f3);
      v  = longint'(word) >> (8 * lane_off(nb, a));
      v  = v % (longint'(1) << (8 * nb));
      if (nb < 4 && f3[2] == 1'b0 && v >= (longint'(1) << (8 * nb - 1)))
         v = v - (longint'(1) << (8 * nb));
      return 32'(v);
   endfunction

   function automatic logic [31:0] store_ref(input int nb, input logic [31:0] wd);
      longint v;
      longint rep;
      v   = longint'(wd) % (longint'(1) << (8 * nb));
      rep = (nb == 1) ? 64'h01010101 : ((nb == 2) ? 64'h00010001 : 64'h1);
      return 32'(v * rep);
   endfunction

   function automatic txn_t mk(input bit wr, input bit rd, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] word, input int gd, input int rv,
                               input bit hold);
      txn_t t;
      t.wr = wr; t.rd = rd; t.f3 = f3; t.a = a; t.wd = wd; t.word = word;
      t.gd = gd; t.rv = rv; t.hold = hold;
      return t;
   endfunction

   task automatic reset_chk(input string nm);
      chk({nm, "_ctrl"}, {stall, dmem_req, dmem_we, dmem_be, bus_err, misaligned}, 0);
      chk({nm, "_dmem_addr"}, dmem_addr, 0);
      chk({nm, "_dmem_wdata"}, dmem_wdata, 0);
      chk({nm, "_rdata"}, rdata, 0);
   endtask

   // Issue one access at posedge+2, act as the memory, and hold inputs through DONE
   task automatic run_txn(input txn_t t);
      exp_req_t  er;
      exp_done_t ed;
      bit        trap, granted, done;
      int        nb, req_cyc, since;
      nb   = nbytes(t.wr, t.f3);
      trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (int'(t.a % 4) % nb) != 0;
`endif
      er.we     = t.wr;
      er.addr   = (t.a / 4) * 4;
      er.be     = 4'(((1 << nb) - 1) << lane_off(nb, t.a));
      er.chk_be = t.wr || (nb == 4);
      er.wdata  = store_ref(nb, t.wd);
      if (!trap) req_q.push_back(er);
      ed.err = t.hold && !trap;
      ed.mis = trap;
      if (trap) begin
         ed.stall_cyc = 1;
         ed.req_cyc   = 0;
         if (!t.wr) model_rdata = 32'h0;
      end else if (t.hold) begin
         ed.stall_cyc = 1 + MAX_WAIT;
         ed.req_cyc   = MAX_WAIT;
         if (!t.wr) model_rdata = 32'h0;
      end else begin
         ed.req_cyc   = t.gd + 1;
         ed.stall_cyc = t.wr ? (2 + t.gd) : (3 + t.gd + t.rv);
         if (!t.wr) model_rdata = load_ref(t.f3, t.a, t.word);
      end
      ed.rdata = model_rdata;
      done_q.push_back(ed);

      mem_read = t.rd; mem_write = t.wr; func_3 = t.f3; addr = t.a; wdata = t.wd;
      req_cyc = 0; since = 0; granted = 1'b0; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(posedge clk); #2;
         if (!stall) done = 1'b1;
         else begin
            if (dmem_gnt) begin
               granted  = 1'b1;
               dmem_gnt = 1'b0;
            end
            if (!granted && dmem_req && !t.hold) begin
               if (req_cyc == t.gd) dmem_gnt = 1'b1;
               req_cyc++;
            end
            if (granted && !t.wr) begin
               dmem_rvalid = (since == t.rv);
               dmem_rdata  = dmem_rvalid ? t.word : $urandom;
               since++;
            end else dmem_rdata = $urandom;
         end
      end
      if (!done) chk("txn_complete", 0, 1);
      @(posedge clk); #2;
      mem_read = 1'b0; mem_write = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      func_3 = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
   endtask

   // Reset while a load waits for rvalid, then offer a stray rvalid after release
   task automatic reset_mid_wait();
      exp_req_t er;
      er.we = 1'b0; er.addr = 32'h300; er.be = 4'hF; er.chk_be = 1'b1; er.wdata = 32'h0;
      req_q.push_back(er);
      mem_read = 1'b1; mem_write = 1'b0; func_3 = 3'b010; addr = 32'h300;
      @(posedge clk); #2;
      dmem_gnt = 1'b1;
      @(posedge clk); #2;
      dmem_gnt = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      reset_chk("reset_mid_wait");
      @(posedge clk); #2;
      rst_n = 1'b1;
      model_rdata = 32'h0;
      dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'hCAFEF00D;
      repeat (2) begin
         @(negedge clk);
         chk("stray_rvalid_rdata", rdata, 0);
         chk("stray_rvalid_req_stall", {dmem_req, stall}, 0);
      end
      @(posedge clk); #2;
      dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
   endtask

   // Monitor: request fields on dmem_req rising, results on the non-stalled access cycle
   initial begin
      stall_m = 0; reqc_m = 0; req_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_m = 0; reqc_m = 0; req_prev = 1'b0;
         end else begin
            if (dmem_req) begin
               reqc_m++;
               if (!req_prev) begin
                  if (req_q.size() == 0) chk("unexpected_req", 1, 0);
                  else begin
                     mon_er = req_q.pop_front();
                     chk("dmem_we", dmem_we, mon_er.we);
                     chk("dmem_addr", dmem_addr, mon_er.addr);
                     if (mon_er.chk_be) chk("dmem_be", dmem_be, mon_er.be);
                     if (mon_er.we) chk("dmem_wdata", dmem_wdata, mon_er.wdata);
                  end
               end
            end
            req_prev = dmem_req;
            if (mem_read | mem_write) begin
               if (stall) begin
                  stall_m++;
                  chk("no_pulse_while_stalled", {bus_err, misaligned}, 0);
               end else if (done_q.size() == 0) begin
                  chk("unexpected_completion", 1, 0);
               end else begin
                  mon_ed = done_q.pop_front();
                  chk("rdata", rdata, mon_ed.rdata);
                  chk("bus_err", bus_err, mon_ed.err);
                  chk("misaligned", misaligned, mon_ed.mis);
                  chk("stall_cycles", stall_m, mon_ed.stall_cyc);
                  chk("req_cycles", reqc_m, mon_ed.req_cyc);
                  stall_m = 0; reqc_m = 0;
               end
            end else begin
               chk("idle_quiet", {stall, bus_err, misaligned}, 0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within 500000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      txn_t t;
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func_3 = 3'b0;
      addr = 32'h0; wdata = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      model_rdata = 32'h0;
      repeat (2) @(negedge clk);
      reset_chk("reset_state");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      run_txn(mk(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0));
      run_txn(mk(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 1, 0, 1'b0));
      run_txn(mk(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 0, 2, 1'b0));
      run_txn(mk(1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 32'h80AABBCC, 2, 1, 1'b0));
      run_txn(mk(1'b1, 1'b0, 3'b000, 32'h201, 32'h12345678, 32'h0, 0, 0, 1'b0));
      run_txn(mk(1'b1, 1'b0, 3'b001, 32'h202, 32'h12345678, 32'h0, 3, 0, 1'b0));
      reset_mid_wait();
      run_txn(mk(1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'hF00D1234, 0, 0, 1'b0));
      run_txn(mk(1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 32'h0, 0, 0, 1'b1));
      run_txn(mk(1'b0, 1'b1, 3'b000, 32'h401, 32'h0, 32'h00007F00, 0, 0, 1'b0));
      run_txn(mk(1'b1, 1'b0, 3'b010, 32'h500, 32'hABCD0123, 32'h0, 0, 0, 1'b1));
      run_txn(mk(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0, 1'b0));
      run_txn(mk(1'b1, 1'b1, 3'b001, 32'h203, 32'hA5A5BEEF, 32'h0, 1, 0, 1'b0));
      run_txn(mk(1'b1, 1'b0, 3'b010, 32'h102, 32'h01020304, 32'h0, 0, 0, 1'b0));

      for (int i = 0; i < 60; i++) begin
         t.wr   = bit'($urandom_range(0, 1));
         t.rd   = t.wr ? bit'($urandom_range(0, 1)) : 1'b1;
         t.f3   = 3'($urandom_range(0, 7));
         t.a    = $urandom;
         t.wd   = $urandom;
         t.word = $urandom;
         t.gd   = $urandom_range(0, 4);
         t.rv   = $urandom_range(0, 3);
         t.hold = ($urandom_range(0, 15) == 0);
         run_txn(t);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #2;
         end
      end

      repeat (3) @(posedge clk);
      #2;
      chk("req_queue_drained", req_q.size(), 0);
      chk("done_queue_drained", done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
